// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_pkg : shared types and default widths for the board-memory arbiter
// rev 1.0
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_DATA_W    = 6;
  localparam int DEF_NUM_CELLS = 512;
  localparam int DEF_MAX_WAIT  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Tag carried alongside each memory access so the returning word is routed
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_GAME = 2'd1,
    OWN_SCAN = 2'd2
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_if : game-logic request/grant/read-return bus
// rev 1.0
// ----------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_adr;
  logic [DATA_W-1:0] g_wd;
  logic              g_gnt;
  logic              g_rvalid;
  logic [DATA_W-1:0] g_rdata;

  modport master (
    output g_req, g_we, g_adr, g_wd,
    input  g_gnt, g_rvalid, g_rdata
  );

  modport slave (
    input  g_req, g_we, g_adr, g_wd,
    output g_gnt, g_rvalid, g_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_scan_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter_scan_counter : frame scan pointer, scanner starvation counter
// rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter_scan_counter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_CELLS = DEF_NUM_CELLS,
  parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              want,
  input  logic              gnt,
  input  logic [ADDR_W-1:0] cmp_adr,
  output logic [ADDR_W-1:0] scan_adr,
  output logic              ptr_end,
  output logic              wait_max,
  output logic              cmp_last
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W:0]   c_num_cells = (ADDR_W + 1)'(NUM_CELLS);
  localparam logic [ADDR_W-1:0] c_last_adr  = ADDR_W'(NUM_CELLS - 1);
  localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(MAX_WAIT);

  // One extra bit so the pointer can park at NUM_CELLS after the last grant
  logic [ADDR_W:0]   r_ptr;
  logic [WAIT_W-1:0] r_wait;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_wait <= '0;
    end else begin
      if (clear)
        r_ptr <= '0;
      else if (gnt && !ptr_end)
        r_ptr <= r_ptr + (ADDR_W + 1)'(1);

      if (want && !gnt) begin
        if (r_wait != c_wait_max)
          r_wait <= r_wait + WAIT_W'(1);
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign scan_adr = r_ptr[ADDR_W-1:0];
  assign ptr_end  = (r_ptr == c_num_cells);
  assign wait_max = (r_wait == c_wait_max);
  assign cmp_last = (cmp_adr == c_last_adr);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_arbiter : shares the single-port board memory between game logic and scanner
// rev 1.0
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_CELLS = DEF_NUM_CELLS,
  parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  mem_arbiter_if.slave      gbus,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_adr,
  output logic [DATA_W-1:0] pix_data,
  output logic              frame_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [1:0] c_idle = IDLE;
  localparam logic [1:0] c_scan = SCAN;
  localparam logic [1:0] c_done = DONE;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  owner_t            r_tag;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_wd;
  logic              r_g_rvalid;
  logic [DATA_W-1:0] r_g_rdata;
  logic              r_pix_valid;
  logic [ADDR_W-1:0] r_pix_adr;
  logic [DATA_W-1:0] r_pix_data;

  logic [ADDR_W-1:0] w_scan_adr;
  logic              w_ptr_end;
  logic              w_wait_max;
  logic              w_pix_last;
  logic              w_frame_start;
  logic              w_scan_want;
  logic              w_scan_gnt;
  logic              w_accept;

  assign w_frame_start = (r_state == c_idle) && scan_start;
  assign w_accept      = r_pix_valid && pix_ready;

  // Single outstanding scan read into a one-entry pixel buffer
  assign w_scan_want = (r_state == c_scan) && !r_pix_valid &&
                       (r_tag != OWN_SCAN) && !w_ptr_end;
  assign w_scan_gnt  = w_scan_want && (w_wait_max || !gbus.g_req);
  assign gbus.g_gnt  = gbus.g_req && !w_scan_gnt;

  mem_arbiter_scan_counter #(
    .ADDR_W    (ADDR_W),
    .NUM_CELLS (NUM_CELLS),
    .MAX_WAIT  (MAX_WAIT)
  ) u_scan_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_frame_start),
    .want     (w_scan_want),
    .gnt      (w_scan_gnt),
    .cmp_adr  (r_pix_adr),
    .scan_adr (w_scan_adr),
    .ptr_end  (w_ptr_end),
    .wait_max (w_wait_max),
    .cmp_last (w_pix_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (scan_start) w_state_nxt = c_scan;
      c_scan:  if (w_accept && w_pix_last) w_state_nxt = c_done;
      c_done:  w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= c_idle;
      r_tag       <= OWN_NONE;
      r_mem_we    <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_wd    <= '0;
      r_g_rvalid  <= 1'b0;
      r_g_rdata   <= '0;
      r_pix_valid <= 1'b0;
      r_pix_adr   <= '0;
      r_pix_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= gbus.g_gnt && gbus.g_we;
      if (w_scan_gnt) begin
        r_mem_adr <= w_scan_adr;
        r_tag     <= OWN_SCAN;
      end else if (gbus.g_gnt) begin
        r_mem_adr <= gbus.g_adr;
        r_mem_wd  <= gbus.g_wd;
        r_tag     <= gbus.g_we ? OWN_NONE : OWN_GAME;
      end else begin
        r_tag <= OWN_NONE;
      end

      // mem_adr still holds the address whose data is arriving on mem_rd
      r_g_rvalid <= (r_tag == OWN_GAME);
      if (r_tag == OWN_GAME)
        r_g_rdata <= mem_rd;

      if (r_tag == OWN_SCAN) begin
        r_pix_valid <= 1'b1;
        r_pix_data  <= mem_rd;
        r_pix_adr   <= r_mem_adr;
      end else if (w_accept) begin
        r_pix_valid <= 1'b0;
      end
    end
  end

  assign gbus.g_rvalid = r_g_rvalid;
  assign gbus.g_rdata  = r_g_rdata;
  assign scan_busy     = (r_state == c_scan);
  assign frame_done    = (r_state == c_done);
  assign pix_valid     = r_pix_valid;
  assign pix_adr       = r_pix_adr;
  assign pix_data      = r_pix_data;
  assign mem_we        = r_mem_we;
  assign mem_adr       = r_mem_adr;
  assign mem_wd        = r_mem_wd;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_arbiter : randomized self-checking bench with board-memory model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 9;
  localparam int DW = 6;
  localparam int NC = 512;
  localparam int MW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          scan_start, scan_busy, pix_valid, pix_ready, frame_done, mem_we;
  logic [AW-1:0] pix_adr, mem_adr;
  logic [DW-1:0] pix_data, mem_wd, mem_rd;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) gbus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_CELLS(NC), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .gbus(gbus), .scan_start(scan_start),
    .scan_busy(scan_busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_adr(pix_adr), .pix_data(pix_data), .frame_done(frame_done),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Board memory plus the bench's view of its contents (with last-write history)
  logic [DW-1:0] ram      [NC];
  logic [DW-1:0] ref_mem  [NC];
  logic [DW-1:0] prev_val [NC];
  int            lastwr   [NC];
  logic [DW-1:0] pix_seen [NC];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < NC; i++) begin
      ram[i] = DW'($urandom);
      ref_mem[i] = ram[i];
      prev_val[i] = ram[i];
      lastwr[i] = -1;
      pix_seen[i] = '0;
    end
    mem_rd = '0;
    forever begin
      @(negedge clk);
      if (mem_we) ram[mem_adr] = mem_wd;
      else        mem_rd = ram[mem_adr];
    end
  end

  task automatic ref_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    prev_val[a] = ref_mem[a];
    lastwr[a]   = cyc;
    ref_mem[a]  = d;
  endtask

  task automatic drive_idle();
    gbus.g_req = 1'b0; gbus.g_we = 1'b0; gbus.g_adr = '0; gbus.g_wd = '0;
    scan_start = 1'b0; pix_ready = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // gmode: 0 no game traffic, 1 game always requesting, 2 random game traffic
  task automatic scan_frame(input int gmode, input bit gaps, input int stall_at,
                            input int restart_k, input bit directed, input int stop_adr,
                            output int npix, output int ndone, output int nslots);
    bit has_cmd = 0, fin = 0, pv_prev = 0, first_slot = 1, want22 = 0, want11 = 0;
    logic c_we = 0;
    logic [AW-1:0] c_adr = '0, h_adr = '0;
    logic [DW-1:0] c_wd = '0, h_data = '0, expd;
    bit ev [2];
    logic [DW-1:0] ed [2];
    int exp_adr = 0, last_slot = 0, stall_n = 0, gcyc;
    ev[0] = 0; ev[1] = 0; ed[0] = '0; ed[1] = '0;
    npix = 0; ndone = 0; nslots = 0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      scan_start = (k == 0) || (k == restart_k);
      pix_ready  = !(exp_adr == stall_at && stall_n < 20);
      if (!pix_ready) stall_n++;
      if (directed && k == 10) want22 = 1;
      if (gmode != 0 && !has_cmd) begin
        if (directed && want22) begin
          c_we = 1; c_adr = AW'(400); c_wd = 6'h22; want22 = 0; has_cmd = 1;
        end else if (directed && want11) begin
          c_we = 1; c_adr = AW'(3); c_wd = 6'h11; want11 = 0; has_cmd = 1;
        end else if (gmode == 1 || $urandom_range(0, 1) == 1) begin
          c_we  = 1'($urandom_range(0, 1));
          c_adr = AW'($urandom_range(0, NC - 1));
          if (directed && (c_adr == AW'(3) || c_adr == AW'(400))) c_adr = AW'(7);
          c_wd = DW'($urandom);
          has_cmd = 1;
        end
      end
      gbus.g_req = has_cmd; gbus.g_we = c_we; gbus.g_adr = c_adr; gbus.g_wd = c_wd;
      @(negedge clk);
      n_total++;
      if (gbus.g_rvalid !== ev[0] || (ev[0] && gbus.g_rdata !== ed[0]))
        $display("FAIL scan_game_read k=%0d: rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                 k, gbus.g_rvalid, gbus.g_rdata, ev[0], ed[0]);
      else n_pass++;
      if (scan_busy && gbus.g_req && !gbus.g_gnt) begin
        nslots++;
        if (gaps) begin
          n_total++;
          if ((k - last_slot) !== (first_slot ? MW + 1 : MW + 3))
            $display("FAIL scan_slot_gap k=%0d: gap=%0d required=%0d",
                     k, k - last_slot, first_slot ? MW + 1 : MW + 3);
          else n_pass++;
          first_slot = 0;
        end
        last_slot = k;
      end
      if (pix_valid && !pix_ready && gbus.g_req) begin
        n_total++;
        if (gbus.g_gnt !== 1'b1)
          $display("FAIL stall_game_gnt k=%0d: g_gnt=%b required=1", k, gbus.g_gnt);
        else n_pass++;
      end
      if (pix_valid && exp_adr < NC) begin
        n_total++;
        if (!pv_prev) begin
          gcyc = cyc - 2;
          expd = (lastwr[exp_adr] > gcyc) ? prev_val[exp_adr] : ref_mem[exp_adr];
          if ({pix_adr, pix_data} !== {AW'(exp_adr), expd})
            $display("FAIL pixel k=%0d: adr=%0d data=%h, required adr=%0d data=%h",
                     k, pix_adr, pix_data, exp_adr, expd);
          else n_pass++;
          h_adr = pix_adr; h_data = pix_data; pix_seen[exp_adr] = pix_data;
        end else begin
          if ({pix_adr, pix_data} !== {h_adr, h_data})
            $display("FAIL pixel_hold k=%0d: adr=%0d data=%h, required adr=%0d data=%h",
                     k, pix_adr, pix_data, h_adr, h_data);
          else n_pass++;
        end
        if (pix_ready) begin
          npix++;
          if (directed && exp_adr == 3) want11 = 1;
          if (exp_adr == stop_adr) fin = 1;
          exp_adr++;
          pv_prev = 0;
        end else pv_prev = 1;
      end
      if (frame_done) begin ndone++; fin = 1; end
      ev[0] = ev[1]; ed[0] = ed[1];
      ev[1] = gbus.g_gnt && !gbus.g_we;
      ed[1] = ref_mem[gbus.g_adr];
      if (gbus.g_gnt) begin
        if (gbus.g_we) ref_write(gbus.g_adr, gbus.g_wd);
        has_cmd = 0;
      end
      next_cycle();
    end
    drive_idle();
    n_total++;
    if (!fin) $display("FAIL frame_timeout: finished=0 required=1");
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({gbus.g_gnt, gbus.g_rvalid, scan_busy, pix_valid, frame_done, mem_we} !== 6'b0)
      $display("FAIL reset_ctl: got %b required 000000",
               {gbus.g_gnt, gbus.g_rvalid, scan_busy, pix_valid, frame_done, mem_we});
    else n_pass++;
    n_total++;
    if ({gbus.g_rdata, pix_data, mem_wd, pix_adr, mem_adr} !== '0)
      $display("FAIL reset_data: got %h required 0",
               {gbus.g_rdata, pix_data, mem_wd, pix_adr, mem_adr});
    else n_pass++;
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_game_rw();
    gbus.g_req = 1; gbus.g_we = 1; gbus.g_adr = AW'(5); gbus.g_wd = 6'h2A;
    @(negedge clk);
    n_total++;
    if (gbus.g_gnt !== 1'b1) $display("FAIL wr_gnt: got %b required 1", gbus.g_gnt);
    else n_pass++;
    ref_write(AW'(5), 6'h2A);
    next_cycle();
    gbus.g_req = 0;
    @(negedge clk);
    n_total++;
    if ({mem_we, mem_adr, mem_wd} !== {1'b1, AW'(5), 6'h2A})
      $display("FAIL wr_mem: got we=%b adr=%0d wd=%h required we=1 adr=5 wd=2a",
               mem_we, mem_adr, mem_wd);
    else n_pass++;
    next_cycle();
    gbus.g_req = 1; gbus.g_we = 0;
    @(negedge clk);
    n_total++;
    if ({gbus.g_gnt, mem_we} !== 2'b10)
      $display("FAIL rd_gnt: got gnt=%b mem_we=%b required gnt=1 mem_we=0", gbus.g_gnt, mem_we);
    else n_pass++;
    next_cycle();
    gbus.g_req = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_total++;
      if (gbus.g_rvalid !== (i == 2) || (i == 2 && gbus.g_rdata !== 6'h2A))
        $display("FAIL rd_return cyc+%0d: rvalid=%b rdata=%h required rvalid=%b rdata=2a",
                 i, gbus.g_rvalid, gbus.g_rdata, i == 2);
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_random_game();
    bit ev [2];
    logic [DW-1:0] ed [2];
    bit wprev = 0;
    ev[0] = 0; ev[1] = 0; ed[0] = '0; ed[1] = '0;
    for (int k = 0; k < 300; k++) begin
      gbus.g_req = 1'($urandom_range(0, 1));
      gbus.g_we  = 1'($urandom_range(0, 1));
      gbus.g_adr = AW'($urandom_range(0, NC - 1));
      gbus.g_wd  = DW'($urandom);
      @(negedge clk);
      n_total++;
      if (gbus.g_gnt !== gbus.g_req || mem_we !== wprev ||
          gbus.g_rvalid !== ev[0] || (ev[0] && gbus.g_rdata !== ed[0]))
        $display("FAIL rand_game k=%0d: gnt=%b we=%b rv=%b rd=%h required gnt=%b we=%b rv=%b rd=%h",
                 k, gbus.g_gnt, mem_we, gbus.g_rvalid, gbus.g_rdata,
                 gbus.g_req, wprev, ev[0], ed[0]);
      else n_pass++;
      ev[0] = ev[1]; ed[0] = ed[1];
      ev[1] = gbus.g_req && !gbus.g_we;
      ed[1] = ref_mem[gbus.g_adr];
      wprev = gbus.g_req && gbus.g_we;
      if (gbus.g_req && gbus.g_we) ref_write(gbus.g_adr, gbus.g_wd);
      next_cycle();
    end
    drive_idle();
    repeat (3) next_cycle();
  endtask

  task automatic test_scan_basic();
    int np, nd, ns;
    scan_frame(0, 0, -1, 300, 0, -1, np, nd, ns);
    @(negedge clk);
    n_total++;
    if (np !== NC || nd !== 1 || scan_busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL scan_basic: pix=%0d done=%0d busy=%b fd=%b required pix=%0d done=1 busy=0 fd=0",
               np, nd, scan_busy, frame_done, NC);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_game_priority();
    int np, nd, ns;
    scan_frame(1, 1, -1, -1, 0, -1, np, nd, ns);
    n_total++;
    if (np !== NC || nd !== 1 || ns !== NC)
      $display("FAIL priority_frame: pix=%0d done=%0d slots=%0d required %0d/1/%0d",
               np, nd, ns, NC, NC);
    else n_pass++;
    repeat (3) next_cycle();
  endtask

  task automatic test_stall();
    int np, nd, ns;
    scan_frame(1, 0, 200, -1, 0, -1, np, nd, ns);
    n_total++;
    if (np !== NC || nd !== 1)
      $display("FAIL stall_frame: pix=%0d done=%0d required %0d/1", np, nd, NC);
    else n_pass++;
    repeat (3) next_cycle();
  endtask

  task automatic test_frame_consistency();
    int np, nd, ns;
    logic [DW-1:0] old3;
    old3 = ref_mem[3];
    scan_frame(2, 0, -1, -1, 1, -1, np, nd, ns);
    n_total++;
    if (np !== NC || pix_seen[3] !== old3 || pix_seen[400] !== 6'h22)
      $display("FAIL consist_f1: pix=%0d p3=%h p400=%h required %0d/%h/22",
               np, pix_seen[3], pix_seen[400], NC, old3);
    else n_pass++;
    repeat (3) next_cycle();
    scan_frame(0, 0, -1, -1, 0, -1, np, nd, ns);
    n_total++;
    if (np !== NC || pix_seen[3] !== 6'h11 || pix_seen[400] !== 6'h22)
      $display("FAIL consist_f2: pix=%0d p3=%h p400=%h required %0d/11/22",
               np, pix_seen[3], pix_seen[400], NC);
    else n_pass++;
    repeat (3) next_cycle();
  endtask

  task automatic test_reset_midscan();
    int np, nd, ns;
    bit bad = 0;
    scan_frame(0, 0, -1, -1, 0, 100, np, nd, ns);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if ({gbus.g_gnt, gbus.g_rvalid, scan_busy, pix_valid, frame_done, mem_we,
           pix_adr, mem_adr, pix_data, mem_wd, gbus.g_rdata} !== '0)
        $display("FAIL midscan_reset_out: busy=%b pv=%b fd=%b adr=%0d required all 0",
                 scan_busy, pix_valid, frame_done, pix_adr);
      else n_pass++;
      next_cycle();
    end
    reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (frame_done || scan_busy || pix_valid || gbus.g_rvalid) bad = 1;
      next_cycle();
    end
    n_total++;
    if (bad) $display("FAIL midscan_quiet: activity=1 required 0");
    else n_pass++;
    scan_frame(0, 0, -1, -1, 0, -1, np, nd, ns);
    n_total++;
    if (np !== NC || nd !== 1)
      $display("FAIL midscan_restart: pix=%0d done=%0d required %0d/1", np, nd, NC);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_game_rw();
    test_random_game();
    test_scan_basic();
    test_game_priority();
    test_stall();
    test_frame_consistency();
    test_reset_midscan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
